// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle from ID through the EX, MEM
// and WB stage registers. It also detects load-use hazards, inserts bubbles
// on stall/flush, and produces the EX-stage operand forwarding selects.
module ctrl_pipe #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              id_jumpmux,
    input  logic              id_umux,
    input  logic              id_jumprmux,
    input  logic [1:0]        id_memtoreg,
    input  logic [1:0]        id_aluop,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_alusrc,
    output logic              ex_branch,
    output logic              ex_jumpmux,
    output logic              ex_umux,
    output logic              ex_jumprmux,
    output logic [1:0]        ex_aluop,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              wb_regwrite,
    output logic [1:0]        wb_memtoreg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // EX fields that are not consumed in EX itself but travel further down
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;
    logic [1:0]        ex_memtoreg;
    logic [REG_AW-1:0] ex_rd;

    // MEM fields that only feed WB and the forwarding compare
    logic              mem_regwrite;
    logic [1:0]        mem_memtoreg;
    logic [REG_AW-1:0] mem_rd;

    logic raw_hazard;
    logic ex_bubble;
    logic count_bubble;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A load in EX whose destination is read by the instruction in ID cannot
    // forward in time; x0 is never a real dependency.
    assign raw_hazard = id_valid & ex_memread & (ex_rd != '0) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A flush discards the ID instruction anyway, so holding it is pointless.
    assign stall = raw_hazard & ~flush;

    assign count_bubble = flush | stall;
    assign ex_bubble    = count_bubble | ~id_valid;

    // EX stage register: loads the ID bundle or a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jumpmux  <= 1'b0;
            ex_umux     <= 1'b0;
            ex_jumprmux <= 1'b0;
            ex_memtoreg <= 2'b00;
            ex_aluop    <= 2'b00;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else if (ex_bubble) begin
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jumpmux  <= 1'b0;
            ex_umux     <= 1'b0;
            ex_jumprmux <= 1'b0;
            ex_memtoreg <= 2'b00;
            ex_aluop    <= 2'b00;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else begin
            ex_alusrc   <= id_alusrc;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_branch   <= id_branch;
            ex_jumpmux  <= id_jumpmux;
            ex_umux     <= id_umux;
            ex_jumprmux <= id_jumprmux;
            ex_memtoreg <= id_memtoreg;
            ex_aluop    <= id_aluop;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
        end
    end

    // MEM stage register: always follows EX, never holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_memtoreg <= 2'b00;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_rd       <= '0;
        end else begin
            mem_memtoreg <= ex_memtoreg;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_rd       <= ex_rd;
        end
    end

    // WB stage register: always follows MEM, never holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_memtoreg <= 2'b00;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
        end else begin
            wb_memtoreg <= mem_memtoreg;
            wb_regwrite <= mem_regwrite;
            wb_rd       <= mem_rd;
        end
    end

    // Forwarding selects: the younger producer (MEM) wins over WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
            fwd_a = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            fwd_a = 2'b01;
        end
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
            fwd_b = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
            fwd_b = 2'b01;
        end
    end

    // Saturating count of bubbles caused by stall or flush (idle ID not counted)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (count_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a table of instruction-stream vectors with
// hand-computed stall/forwarding/count values, plus hand-written sequences
// for latency, asynchronous reset and counter saturation.
module tb_ctrl_pipe;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic              id_alusrc, id_regwrite, id_memread, id_memwrite;
    logic              id_branch, id_jumpmux, id_umux, id_jumprmux;
    logic [1:0]        id_memtoreg, id_aluop;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              flush;
    logic              stall;
    logic              ex_alusrc, ex_branch, ex_jumpmux, ex_umux, ex_jumprmux;
    logic [1:0]        ex_aluop;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic              mem_memread, mem_memwrite;
    logic              wb_regwrite;
    logic [1:0]        wb_memtoreg;
    logic [REG_AW-1:0] wb_rd;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_pipe #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_jumpmux(id_jumpmux), .id_umux(id_umux),
        .id_jumprmux(id_jumprmux), .id_memtoreg(id_memtoreg), .id_aluop(id_aluop),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
        .ex_jumpmux(ex_jumpmux), .ex_umux(ex_umux), .ex_jumprmux(ex_jumprmux),
        .ex_aluop(ex_aluop), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic             v;
        logic             ld;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             fl;
        logic             st;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic ld, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic fl,
                       input logic st, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [CNT_W-1:0] cnt);
        vec_t r;
        r.v = v; r.ld = ld; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.fl = fl;
        r.st = st; r.fa = fa; r.fb = fb; r.cnt = cnt;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ld=1: load (alusrc, memread, memtoreg=01); ld=0: ALU op (aluop=10)
    task automatic drive(input logic v, input logic ld, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic fl);
        id_valid    = v;
        id_regwrite = v;
        id_memread  = v & ld;
        id_alusrc   = v & ld;
        id_memwrite = 1'b0;
        id_branch   = 1'b0;
        id_jumpmux  = 1'b0;
        id_umux     = 1'b0;
        id_jumprmux = 1'b0;
        id_memtoreg = (v & ld) ? 2'b01 : 2'b00;
        id_aluop    = (v & ~ld) ? 2'b10 : 2'b00;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        flush       = fl;
    endtask

    function automatic logic [47:0] all_outs();
        return {stall, ex_alusrc, ex_branch, ex_jumpmux, ex_umux, ex_jumprmux,
                ex_aluop, ex_rs1, ex_rs2, mem_memread, mem_memwrite, wb_regwrite,
                wb_memtoreg, wb_rd, fwd_a, fwd_b, bubble_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // Latency: one full bundle, then idle; each stage shows it one cycle later
        id_valid = 1'b1; id_alusrc = 1'b1; id_regwrite = 1'b1; id_memread = 1'b1;
        id_memwrite = 1'b1; id_branch = 1'b1; id_jumpmux = 1'b1; id_umux = 1'b1;
        id_jumprmux = 1'b1; id_memtoreg = 2'b10; id_aluop = 2'b11;
        id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd7; flush = 1'b0;
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lat_ex", 64'({ex_alusrc, ex_branch, ex_jumpmux, ex_umux, ex_jumprmux,
                           ex_aluop, ex_rs1, ex_rs2}), 64'({5'b11111, 2'b11, 5'd3, 5'd4}));
        chk("lat_mem_early", 64'({mem_memread, mem_memwrite}), 64'd0);
        tick();
        chk("lat_mem", 64'({mem_memread, mem_memwrite}), 64'b11);
        chk("lat_ex_bubble", 64'({ex_alusrc, ex_aluop, ex_rs1}), 64'd0);
        tick();
        chk("lat_wb", 64'({wb_regwrite, wb_memtoreg, wb_rd}), 64'({1'b1, 2'b10, 5'd7}));
        chk("lat_cnt", 64'(bubble_cnt), 64'd0);
        tick();
        tick();

        // Instruction stream: values checked before the edge that consumes the row
        add(1,1, 1, 0, 5,0, 0,2'b00,2'b00,0); // LW x5,0(x1)
        add(1,0, 5, 7, 6,0, 1,2'b00,2'b00,0); // ADD x6,x5,x7 -> load-use stall
        add(1,0, 5, 7, 6,0, 0,2'b00,2'b00,1); // held ADD, hazard gone
        add(0,0, 0, 0, 0,0, 0,2'b01,2'b00,1); // ADD in EX, load in WB
        add(1,0, 1, 2, 3,0, 0,2'b00,2'b00,1); // ADD x3
        add(1,0, 1, 2, 3,0, 0,2'b00,2'b00,1); // ADD x3
        add(1,0, 3, 3, 4,0, 0,2'b00,2'b00,1); // ADD x4,x3,x3
        add(0,0, 0, 0, 0,0, 0,2'b10,2'b10,1); // MEM beats WB on both operands
        add(1,0, 1, 2, 8,0, 0,2'b00,2'b00,1); // ADD x8
        add(0,0, 0, 0, 0,0, 0,2'b00,2'b00,1);
        add(1,0, 8, 0, 9,0, 0,2'b00,2'b00,1); // ADD x9,x8,x0
        add(0,0, 0, 0, 0,0, 0,2'b01,2'b00,1); // producer two back -> WB
        add(1,1, 1, 0, 5,0, 0,2'b00,2'b00,1); // LW x5
        add(1,0, 5, 7, 6,1, 0,2'b00,2'b00,1); // dependent + flush: no stall
        add(0,0, 0, 0, 0,0, 0,2'b00,2'b00,2); // one bubble counted
        add(1,1, 1, 0, 0,0, 0,2'b00,2'b00,2); // LW x0
        add(1,0, 0, 0, 1,0, 0,2'b00,2'b00,2); // ADD x1,x0,x0: no stall
        add(0,0, 0, 0, 0,0, 0,2'b00,2'b00,2); // rd=0 in MEM: no forward
        add(0,0, 0, 0, 0,0, 0,2'b00,2'b00,2); // rd=0 in WB: no forward
        add(1,1, 1, 0,12,0, 0,2'b00,2'b00,2); // LW x12
        add(1,0, 2,12,13,0, 1,2'b00,2'b00,2); // ADD x13,x2,x12 -> stall via rs2
        add(1,0, 2,12,13,0, 0,2'b00,2'b00,3);
        add(0,0, 0, 0, 0,0, 0,2'b00,2'b01,3); // rs2 from WB

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].ld, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].fl);
            #1;
            chk($sformatf("row%0d_stall", i), 64'(stall), 64'(tbl[i].st));
            chk($sformatf("row%0d_fwd_a", i), 64'(fwd_a), 64'(tbl[i].fa));
            chk($sformatf("row%0d_fwd_b", i), 64'(fwd_b), 64'(tbl[i].fb));
            chk($sformatf("row%0d_cnt", i), 64'(bubble_cnt), 64'(tbl[i].cnt));
            tick();
        end

        // Mid-stream reset: fill all stages with ADD x3,x1,x2, then pulse reset off-edge
        drive(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_outputs", 64'(all_outs()), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("postreset_hold", 64'(all_outs()), 64'd0);
        tick();
        chk("postreset_ex", 64'({ex_rs1, ex_rs2, ex_aluop}), 64'({5'd1, 5'd2, 2'b10}));
        chk("postreset_mem", 64'({mem_memread, wb_regwrite}), 64'd0);
        chk("postreset_cnt", 64'(bubble_cnt), 64'd0);

        // Saturation: 2^CNT_W + 3 flushes
        drive(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
        for (int i = 1; i <= (1 << CNT_W) + 3; i++) begin
            tick();
            if (i == 1)
                chk("sat_first", 64'(bubble_cnt), 64'd1);
            if (i == (1 << CNT_W) - 2)
                chk("sat_below", 64'(bubble_cnt), 64'((1 << CNT_W) - 2));
            if (i == (1 << CNT_W) - 1)
                chk("sat_reach", 64'(bubble_cnt), 64'((1 << CNT_W) - 1));
        end
        chk("sat_hold", 64'(bubble_cnt), 64'((1 << CNT_W) - 1));
        chk("sat_ex_bubble", 64'({ex_rs1, ex_aluop}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelines the decoded control bundle from the ID stage through the EX, MEM and WB stage registers of the RISC-V core. Detects load-use hazards and drives the stall. Applies bubble insertion on stall and flush. Generates EX-stage operand forwarding selects. It sits between the opcode decoder (ID) and the datapath stage muxes; the decoder produces the bundle, this block carries it to where each bit is consumed.

## Interface
Parameters:
- REG_AW, 5, register-address width (rs1/rs2/rd).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_valid  in  1  ID holds a real instruction.
- id_alusrc, id_regwrite, id_memread, id_memwrite, id_branch, id_jumpmux, id_umux, id_jumprmux  in  1 each  decoded controls.
- id_memtoreg  in  2  writeback select.
- id_aluop  in  2  ALU op class.
- id_rs1, id_rs2, id_rd  in  REG_AW  ID register fields.
- flush  in  1  taken branch/jump resolved in EX this cycle.
- stall  out  1  hold PC and IF/ID; combinational.
- ex_alusrc, ex_branch, ex_jumpmux, ex_umux, ex_jumprmux  out  1 each; ex_aluop  out  2; ex_rs1, ex_rs2  out  REG_AW.
- mem_memread, mem_memwrite  out  1 each.
- wb_regwrite  out  1; wb_memtoreg  out  2; wb_rd  out  REG_AW.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 from MEM, 01 from WB.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

## Operation
- Stage registers: EX holds the full bundle plus rs1/rs2/rd. MEM holds memtoreg, regwrite, memread, memwrite, rd. WB holds memtoreg, regwrite, rd.
- A bubble is an all-zero bundle with rd=0.
- Raw hazard: id_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - rs fields are compared for every opcode; spurious stalls on LUI/JAL/AUIPC are accepted.
- stall = raw hazard & ~flush.
- EX load priority: reset > flush > stall > ID bundle.
  - flush or stall: EX loads a bubble.
  - id_valid=0: EX loads a bubble.
- MEM always loads from EX; WB always loads from MEM. No stage below EX ever holds.
- fwd_a:
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
  - else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - else 00.
- fwd_b: same rules against ex_rs2. MEM beats WB when both match.
- The load-use stall guarantees that a MEM-stage load never forwards its address as data.
- bubble_cnt increments by 1 on each edge where EX loads a bubble because of stall or flush (not id_valid=0). It saturates at all-ones.

## Timing
- Reset: all stage registers are bubbles. Every output is 0: stall=0, fwd_a=fwd_b=00, bubble_cnt=0.
- Latency: an ID bundle appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- stall and fwd_* are combinational from current register state and ID inputs, valid in the same cycle.
- Load-use: stall is high for exactly one cycle. On the next cycle the load is in MEM, so the raw hazard clears and the dependent instruction enters EX with fwd=01 one cycle after that.
- flush and raw hazard in the same cycle: stall=0, EX gets a bubble, bubble_cnt +1 (once).
- Reset asserted mid-operation clears all stages within the same cycle, independent of clk. The first edge after deassertion loads normally.
- rd=0 never forwards and never stalls.

## Test plan
- Reset mid-stream: pulse reset with all stages holding nonzero bundles -> all outputs 0 before the next clk edge, bubble_cnt=0.
- Load-use: LW x5 then ADD x6,x5,x7 -> stall=1 for exactly one cycle; ADD reaches EX one cycle late with fwd_a=01; bubble_cnt=1.
- Forward priority: ADD x3 ; ADD x3 ; ADD x4,x3,x3 back-to-back -> third in EX shows fwd_a=fwd_b=10. A single producer two instructions earlier -> 01.
- Flush+stall collision: LW x5 in EX, dependent in ID, flush=1 -> stall=0, EX bubble, bubble_cnt +1 only.
- x0 guard: LW x0 then ADD x1,x0,x0 -> stall=0, fwd_a=fwd_b=00.
- Saturation: force 2^CNT_W+3 flushes -> bubble_cnt holds at all-ones.
